dmem_arbiter: RTL

//  Shares the single-port data memory (memory2c) between two requesters: port 0 = memory stage
//  (load/store), port 1 = secondary master (fetch/debug). Sequences each access as issue ->

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: issue -> fixed-latency wait -> done,
// plus the halt sequence (drain in-flight access, one createdump cycle, then park).
module dmem_arbiter #(
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_wr,
   input  logic [15:0] p0_addr,
   input  logic [15:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_done,
   output logic [15:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_wr,
   input  logic [15:0] p1_addr,
   input  logic [15:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_done,
   output logic [15:0] p1_rdata,
   input  logic        halt,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_dump,
   input  logic [15:0] mem_rdata,
   output logic        busy,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DUMP, S_HALTED
   } state_t;

   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

   state_t           r_state;
   logic             r_sel;
   logic             r_last;
   logic             r_wr;
   logic [15:0]      r_addr;
   logic [15:0]      r_wdata;
   logic [CNT_W-1:0] r_cnt;
   logic             r_halt_pend;
   logic [15:0]      r_p0_rdata;
   logic [15:0]      r_p1_rdata;

   // Round-robin only matters on a tie; a lone requester always wins.
   logic w_pick;
   assign w_pick = (p0_req && p1_req) ? ~r_last : p1_req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_sel       <= 1'b0;
         r_last      <= 1'b1;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_halt_pend <= 1'b0;
         r_p0_rdata  <= '0;
         r_p1_rdata  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (halt) begin
                  r_state <= S_DUMP;
               end else if (p0_req || p1_req) begin
                  r_sel   <= w_pick;
                  r_last  <= w_pick;
                  r_wr    <= w_pick ? p1_wr    : p0_wr;
                  r_addr  <= w_pick ? p1_addr  : p0_addr;
                  r_wdata <= w_pick ? p1_wdata : p0_wdata;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (halt) r_halt_pend <= 1'b1;
               r_cnt   <= CNT_W'(1);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (halt) r_halt_pend <= 1'b1;
               if (r_cnt == LAT_C) begin
                  // Read data lands in the port register so it is visible during DONE.
                  if (!r_wr) begin
                     if (r_sel) r_p1_rdata <= mem_rdata;
                     else       r_p0_rdata <= mem_rdata;
                  end
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (r_halt_pend || halt) r_state <= S_DUMP;
               else                     r_state <= S_IDLE;
            end
            S_DUMP:   r_state <= S_HALTED;
            S_HALTED: r_state <= S_HALTED;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   // Moore decode keeps every strobe tied to the async-reset state register.
   assign mem_en    = (r_state == S_ISSUE);
   assign mem_wr    = mem_en && r_wr;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_dump  = (r_state == S_DUMP);
   assign p0_gnt    = mem_en && !r_sel;
   assign p1_gnt    = mem_en &&  r_sel;
   assign p0_done   = (r_state == S_DONE) && !r_sel;
   assign p1_done   = (r_state == S_DONE) &&  r_sel;
   assign p0_rdata  = r_p0_rdata;
   assign p1_rdata  = r_p1_rdata;
   assign busy      = (r_state != S_IDLE) && (r_state != S_HALTED);
   assign halted    = (r_state == S_HALTED);

endmodule
